// File: rtl/condicionador_botoes_pkg.sv
// Shared constants for the button conditioner and the game's debug decoders:
// state codes, widths, the debounce default and press-classification helpers.
package condicionador_botoes_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_PADRAO = 10;
   localparam int unsigned BOTOES_W               = 4;
   localparam int unsigned ESTADO_W               = 3;
   localparam int unsigned CONTADOR_W             = 8;

   localparam logic [ESTADO_W-1:0] OCIOSO         = 3'd0;
   localparam logic [ESTADO_W-1:0] FILTRA         = 3'd1;
   localparam logic [ESTADO_W-1:0] REGISTRA       = 3'd2;
   localparam logic [ESTADO_W-1:0] ESPERA_SOLTAR  = 3'd3;
   localparam logic [ESTADO_W-1:0] FILTRA_SOLTURA = 3'd4;

   // Exactly one button pressed.
   function automatic logic um_bit(input logic [BOTOES_W-1:0] v);
      return (v != '0) && ((v & (v - BOTOES_W'(1))) == '0);
   endfunction

   // Two or more buttons pressed together.
   function automatic logic multi_bit(input logic [BOTOES_W-1:0] v);
      return (v & (v - BOTOES_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador.sv
// Two-flop synchronizer bringing the raw asynchronous buttons into the
// clock domain before any decision logic looks at them.
module sincronizador_2ff
   import condicionador_botoes_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [BOTOES_W-1:0] d,
   output logic [BOTOES_W-1:0] q
);

   logic [BOTOES_W-1:0] meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: synchronizes, debounces and classifies button presses
// into a held play code plus one-cycle valid/invalid pulses.
module condicionador_botoes
   import condicionador_botoes_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [BOTOES_W-1:0] botoes,
   input  logic                habilita,
   input  logic                limpa,
   output logic [BOTOES_W-1:0] jogada,
   output logic                tem_jogada,
   output logic                invalida,
   output logic [ESTADO_W-1:0] db_estado
);

   localparam logic [CONTADOR_W-1:0] LIMITE       = CONTADOR_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CONTADOR_W-1:0] CONTADOR_MAX = '1;

   logic [BOTOES_W-1:0]   bs;
   logic [ESTADO_W-1:0]   estado, prox_estado;
   logic [BOTOES_W-1:0]   captura, prox_captura;
   logic [CONTADOR_W-1:0] contador, prox_contador;
   logic [CONTADOR_W-1:0] contador_inc;

   sincronizador_2ff u_sincronizador (
      .clock (clock),
      .reset (reset),
      .d     (botoes),
      .q     (bs)
   );

   // Saturating increment; the count never wraps back into a valid window.
   assign contador_inc = (contador == CONTADOR_MAX) ? contador : contador + CONTADOR_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         estado     <= OCIOSO;
         captura    <= '0;
         contador   <= '0;
         jogada     <= '0;
         tem_jogada <= 1'b0;
         invalida   <= 1'b0;
         db_estado  <= OCIOSO;
      end else begin
         estado     <= prox_estado;
         captura    <= prox_captura;
         contador   <= prox_contador;
         tem_jogada <= (estado == REGISTRA) && um_bit(captura);
         invalida   <= (estado == REGISTRA) && multi_bit(captura);
         db_estado  <= prox_estado;
         // A fresh capture outranks a simultaneous clear.
         if (estado == REGISTRA) begin
            jogada <= captura;
         end else if (limpa) begin
            jogada <= '0;
         end
      end
   end

   always_comb begin
      prox_estado   = estado;
      prox_captura  = captura;
      prox_contador = contador;
      case (estado)
         OCIOSO: begin
            if (habilita && (bs != '0)) begin
               prox_estado   = FILTRA;
               prox_captura  = bs;
               prox_contador = '0;
            end
         end
         FILTRA: begin
            if (bs != captura) begin
               prox_estado = OCIOSO;
            end else if (!habilita) begin
               prox_estado = ESPERA_SOLTAR;
            end else begin
               prox_contador = contador_inc;
               if (contador == LIMITE) begin
                  prox_estado = REGISTRA;
               end
            end
         end
         REGISTRA: begin
            prox_estado = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (bs == '0) begin
               prox_estado   = FILTRA_SOLTURA;
               prox_contador = '0;
            end
         end
         FILTRA_SOLTURA: begin
            if (bs != '0) begin
               prox_estado = ESPERA_SOLTAR;
            end else if (contador == LIMITE) begin
               prox_estado = OCIOSO;
            end else begin
               prox_contador = contador_inc;
            end
         end
         default: begin
            prox_estado = OCIOSO;
         end
      endcase
   end

endmodule
